router_out_fifo: RTL and testbench
==================================

// Module: router_out_fifo
// PURPOSE
//  Output-channel FIFO of the 1x3 router. Sits directly downstream of the register stage.
//  Buffers that stage's byte stream (header, payload, parity) for one destination port.
//  Each entry is tagged with the lfd_state header flag.
//  On readout, tracks packet length so data_out drops to 0 between packets.
//  One instance per output port; the FSM/sync block drives write_enb, read_enb and soft_reset.
// PARAMETERS
//  DEPTH  16  number of entries; must be a power of 2
//  AW     4   address width, log2(DEPTH)
//  DW     8   data width in bits; each stored word is DW+1 bits (header tag + data)
// PORTS
//  clock       in   1      rising-edge clock
//  resetn      in   1      synchronous active-low reset
//  soft_reset  in   1      synchronous flush (receiver timeout); active-high
//  write_enb   in   1      write request for data_in
//  read_enb    in   1      read request from the output port
//  lfd_state   in   1      data_in is a header byte; stored as tag bit DW
//  data_in     in   DW     byte from the register stage
//  full        out  1      no free entry
//  empty       out  1      no stored entry
//  data_out    out  DW     registered read data
//  occupancy   out  AW+1   entries stored; port present only with ROUTER_FIFO_OCC_EN
// BEHAVIOUR
//  - Reset: resetn sampled on clock edge, active-low; reset resetn, synchronous, active-low; clock clock.
//    Priority: resetn > soft_reset > normal operation.
//  - resetn=0: wr_ptr=rd_ptr=0, count=0, data_out=0, full=0, empty=1.
//    Memory contents are not cleared.
//  - soft_reset=1: same clear as resetn, except the header tag bits of memory are not touched.
//    Pending write/read in that cycle is discarded.
//  - Pointers are AW+1 bits and wrap modulo 2*DEPTH; entries are addressed by ptr[AW-1:0].
//  - Flags are combinational from the pointers:
//      empty = (wr_ptr == rd_ptr)
//      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
//  - Write is accepted iff write_enb && !full.
//    mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments.
//  - Read is accepted iff read_enb && !empty.
//    data_out <= mem[rd_ptr][DW-1:0] on the next edge (1-cycle latency); rd_ptr increments.
//  - Simultaneous accepted read and write: both pointers advance, so occupancy is unchanged.
//    Flags are evaluated before the edge: when full, the write is refused even if a read occurs;
//    when empty, the read is refused and the write is accepted.
//  - Packet counter count[5:0]:
//      on an accepted read of a word with tag=1: count <= data[7:2] + 1
//        (payload length plus parity byte);
//      on an accepted read of a word with tag=0 and count != 0: count <= count - 1.
//  - data_out idle rule: if no read is accepted and count == 0, data_out <= 0.
//    Otherwise data_out holds its value.
//  - Reading a tag=0 word while count==0 (orphan byte) still outputs the byte; count stays 0.
//  - Refused write/read: no state change (except the idle rule above); no error flag.
// CONFIGURATION
//  ROUTER_FIFO_OCC_EN defined:
//    occupancy port exists; occupancy = wr_ptr - rd_ptr (AW+1 bits), range 0..DEPTH.
//    occupancy is 0 after resetn or soft_reset.
//  ROUTER_FIFO_OCC_EN undefined: no occupancy port and no subtractor; all other behaviour identical.
// TESTING
//  1. resetn=0 for 2 cycles -> empty=1, full=0, data_out=0; occupancy=0 if enabled.
//  2. Write header 8'h0D (len 3, lfd=1), then 8'h11, 8'h22, 8'h33, parity 8'h3F; read 5 words
//     -> data_out = 0D,11,22,33,3F, each one cycle after its read; next idle cycle data_out=0.
//  3. Write 16 words -> full=1 after the 16th; a 17th write is ignored;
//     16 reads return words 1..16 in order, then empty=1.
//  4. Full FIFO, read_enb=write_enb=1 for one cycle -> one word out, write refused, full=0 after.
//     Empty FIFO, both high -> write accepted, read refused, empty=0.
//  5. soft_reset=1 mid-packet (count=2, 3 words stored) -> next cycle empty=1, data_out=0;
//     a new header written and read gives a correct count.
//  6. ROUTER_FIFO_OCC_EN: 5 writes, 2 reads, then 1 simultaneous read/write -> occupancy=3.
//     Pointer wrap after 40 write/read pairs -> occupancy still correct.

Source files
------------

// File: rtl/router_out_fifo.sv
// rtl/router_out_fifo.sv - Router output-channel FIFO with header tag and packet-length tracked readout
// Optional occupancy port enabled by defining ROUTER_FIFO_OCC_EN.
module router_out_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          soft_reset,
    input  logic          write_enb,
    input  logic          read_enb,
    input  logic          lfd_state,
    input  logic [DW-1:0] data_in,
    output logic          full,
    output logic          empty,
`ifdef ROUTER_FIFO_OCC_EN
    output logic [AW:0]   occupancy,
`endif
    output logic [DW-1:0] data_out
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [5:0]    count;
    logic          wr_acc;
    logic          rd_acc;
    logic [DW:0]   rd_word;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];

`ifdef ROUTER_FIFO_OCC_EN
    assign occupancy = wr_ptr - rd_ptr;
`endif

    // Storage has no reset; a write pending during either reset is dropped.
    always_ff @(posedge clock) begin
        if (resetn && !soft_reset && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word[DW-1:0];
                // Header carries payload length in [7:2]; +1 covers the parity byte.
                if (rd_word[DW]) begin
                    count <= rd_word[7:2] + 6'd1;
                end else if (count != 6'd0) begin
                    count <= count - 6'd1;
                end
            end else if (count == 6'd0) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_out_fifo.sv
// tb/tb_router_out_fifo.sv - Directed self-checking bench for router_out_fifo
module tb_router_out_fifo;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       full;
    logic       empty;
    logic [7:0] data_out;
`ifdef ROUTER_FIFO_OCC_EN
    logic [4:0] occupancy;
`endif

    int n_cmp = 0;
    int n_err = 0;

    router_out_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
`ifdef ROUTER_FIFO_OCC_EN
        .occupancy  (occupancy),
`endif
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = lfd;
        step();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic rd();
        read_enb = 1'b1;
        step();
        read_enb = 1'b0;
    endtask

    initial begin
        // Reset
        step();
        step();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'h0);
`ifdef ROUTER_FIFO_OCC_EN
        check("rst_occ", 32'(occupancy), 32'd0);
`endif
        resetn = 1'b1;

        // Single packet: header 0D (len 3) + 3 payload + parity
        wr(8'h0D, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h3F, 1'b0);
        check("pkt_dout_before_read", 32'(data_out), 32'h0);
        rd(); check("pkt_hdr", 32'(data_out), 32'h0D);
        rd(); check("pkt_b1", 32'(data_out), 32'h11);
        step(); check("pkt_hold_midpacket", 32'(data_out), 32'h11);
        rd(); check("pkt_b2", 32'(data_out), 32'h22);
        rd(); check("pkt_b3", 32'(data_out), 32'h33);
        rd(); check("pkt_par", 32'(data_out), 32'h3F);
        check("pkt_empty", 32'(empty), 32'd1);
        step(); check("pkt_idle_zero", 32'(data_out), 32'h0);

        // Fill to full, overflow write ignored, drain in order
        for (int i = 1; i <= 16; i++) begin
            check("fill_not_full", 32'(full), 32'd0);
            wr(8'(i), 1'b0);
        end
        check("fill_full", 32'(full), 32'd1);
        wr(8'hAA, 1'b0);
        check("overflow_full", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            rd();
            check("drain_word", 32'(data_out), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_not_full", 32'(full), 32'd0);
        rd(); check("underflow_dout_zero", 32'(data_out), 32'h0);

        // Simultaneous read/write on full, then on empty
        for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
        check("sim_full_pre", 32'(full), 32'd1);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hEE;
        step();
        write_enb = 1'b0; read_enb = 1'b0;
        check("sim_full_dout", 32'(data_out), 32'h40);
        check("sim_full_after", 32'(full), 32'd0);
        for (int i = 1; i < 16; i++) rd();
        check("sim_full_last", 32'(data_out), 32'h4F);
        check("sim_full_write_refused", 32'(empty), 32'd1);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h55;
        step();
        write_enb = 1'b0; read_enb = 1'b0;
        check("sim_empty_not_empty", 32'(empty), 32'd0);
        check("sim_empty_read_refused", 32'(data_out), 32'h0);
        rd(); check("sim_empty_word", 32'(data_out), 32'h55);
        check("sim_empty_drained", 32'(empty), 32'd1);

        // Soft reset mid-packet: header 0C (count 4), read 3 -> count 2, 3 stored
        wr(8'h0C, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        wr(8'hA4, 1'b0);
        wr(8'hAF, 1'b0);
        rd(); rd(); rd();
        check("sr_pre_dout", 32'(data_out), 32'hA2);
        soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77;
        step();
        soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        check("sr_empty", 32'(empty), 32'd1);
        check("sr_dout", 32'(data_out), 32'h0);
        check("sr_full", 32'(full), 32'd0);
`ifdef ROUTER_FIFO_OCC_EN
        check("sr_occ", 32'(occupancy), 32'd0);
`endif
        // Orphan byte after soft reset: count must be 0 so the next idle clears data_out
        wr(8'h66, 1'b0);
        rd(); check("sr_orphan", 32'(data_out), 32'h66);
        step(); check("sr_count_cleared", 32'(data_out), 32'h0);
        // New packet: header 04 (len 1) -> count 2
        wr(8'h04, 1'b1);
        wr(8'h9A, 1'b0);
        wr(8'h9B, 1'b0);
        rd(); check("sr_new_hdr", 32'(data_out), 32'h04);
        step(); check("sr_new_hold", 32'(data_out), 32'h04);
        rd(); check("sr_new_pay", 32'(data_out), 32'h9A);
        rd(); check("sr_new_par", 32'(data_out), 32'h9B);
        step(); check("sr_new_idle", 32'(data_out), 32'h0);

`ifdef ROUTER_FIFO_OCC_EN
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), 1'b0);
        check("occ_5", 32'(occupancy), 32'd5);
        rd(); rd();
        check("occ_3", 32'(occupancy), 32'd3);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hC5;
        step();
        check("occ_sim", 32'(occupancy), 32'd3);
        for (int i = 0; i < 40; i++) begin
            data_in = 8'(i);
            step();
        end
        write_enb = 1'b0; read_enb = 1'b0;
        check("occ_wrap", 32'(occupancy), 32'd3);
        check("occ_wrap_dout", 32'(data_out), 32'd36);
        rd(); rd(); rd();
        check("occ_drain", 32'(occupancy), 32'd0);
        check("occ_drain_dout", 32'(data_out), 32'd39);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
